branch_pht_predictor: RTL

- Parametrised dynamic branch predictor. Replaces the single global 2-bit state counter used by the pipeline's hazard/forwarding unit.
- Holds a pattern history table (PHT) of N-bit saturating counters, indexed by PC bits.
- Index is optionally XOR-hashed with a global history register (gshare).
- IF stage looks up a prediction; ID stage, where branches resolve, writes back the outcome. Also keeps saturating prediction statistics.

---
 rtl/branch_pht_predictor.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_pht_predictor.sv
// ----------------------------------------------------------------------------
// branch_pht_predictor
//   Dynamic branch direction predictor built around a pattern history table
//   of saturating counters. The IF stage looks a prediction up
//   combinationally; the ID stage writes the resolved outcome back one branch
//   at a time. With GHR_BITS > 0 the table index is XOR-hashed with a global
//   history of resolved outcomes (gshare); with GHR_BITS = 0 it is a plain
//   bimodal table. Saturating statistics count resolved branches and
//   mispredictions.
//
//   History is non-speculative: both the table and the global history change
//   only on a resolved update, so squashed lookups leave no trace. A lookup
//   and an update to the same entry in one cycle see the pre-update counter
//   and the pre-update history; the new value is visible the following cycle.
// ----------------------------------------------------------------------------
module branch_pht_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 0,
    parameter int STAT_BITS  = 16,
    localparam int GW        = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lk_valid,
    input  logic [PC_WIDTH-1:0]   lk_pc,
    output logic                  lk_taken,
    output logic [INDEX_BITS-1:0] lk_index,
    input  logic                  up_valid,
    input  logic [INDEX_BITS-1:0] up_index,
    input  logic                  up_taken,
    input  logic                  up_pred,
    output logic                  mispredict,
    input  logic                  stat_clr,
    output logic [STAT_BITS-1:0]  stat_branches,
    output logic [STAT_BITS-1:0]  stat_miss,
    output logic [GW-1:0]         ghr
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    localparam logic [CTR_BITS-1:0]  CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]  CTR_ZERO = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0]  CTR_ONE  = CTR_BITS'(1);
    localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};
    localparam logic [STAT_BITS-1:0] STAT_ONE = STAT_BITS'(1);

    // ------------------------------------------------------------------
    // Saturating step of a direction counter: up on taken, down otherwise,
    // never wrapping past either end.
    // ------------------------------------------------------------------
    function automatic logic [CTR_BITS-1:0] ctr_step(
        input logic [CTR_BITS-1:0] cur,
        input logic                taken
    );
        logic [CTR_BITS-1:0] res;
        res = cur;
        if (taken) begin
            if (cur != CTR_MAX) begin
                res = cur + CTR_ONE;
            end else begin
                res = cur;
            end
        end else begin
            if (cur != CTR_ZERO) begin
                res = cur - CTR_ONE;
            end else begin
                res = cur;
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Saturating increment of a statistics counter (sticks at all-ones).
    // ------------------------------------------------------------------
    function automatic logic [STAT_BITS-1:0] stat_inc(
        input logic [STAT_BITS-1:0] cur
    );
        logic [STAT_BITS-1:0] res;
        if (cur != STAT_MAX) begin
            res = cur + STAT_ONE;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // State
    logic [ENTRIES-1:0][CTR_BITS-1:0] pht_r;
    logic [GW-1:0]                    ghr_r;
    logic                             mispredict_r;
    logic [STAT_BITS-1:0]             stat_branches_r;
    logic [STAT_BITS-1:0]             stat_miss_r;

    // Combinational helpers
    logic [INDEX_BITS-1:0] ghr_ext_s;
    logic [INDEX_BITS-1:0] idx_s;
    logic [CTR_BITS-1:0]   pht_next_s;
    logic                  miss_s;
    logic                  pc_unused_s;

    // PC bits outside the index field and lk_valid do not influence the
    // prediction; they are folded here so they are visibly consumed.
    assign pc_unused_s = ^{lk_pc[PC_WIDTH-1:INDEX_BITS+2], lk_pc[1:0], lk_valid};

    generate
        if (GHR_BITS > 0) begin : g_gshare
            // History zero-extended to the index width for the gshare hash
            always_comb begin
                ghr_ext_s = INDEX_BITS'(ghr_r);
            end
        end else begin : g_bimodal
            // Bimodal: no history term in the hash
            always_comb begin
                ghr_ext_s = {INDEX_BITS{1'b0}};
            end
        end
    endgenerate

    // Lookup hash and table read; uses the registered (pre-update) state only
    always_comb begin
        idx_s    = lk_pc[INDEX_BITS+1:2] ^ ghr_ext_s;
        lk_index = idx_s;
        lk_taken = pht_r[idx_s][CTR_BITS-1];
    end

    // Next value of the entry addressed by the resolving branch
    always_comb begin
        pht_next_s = ctr_step(pht_r[up_index], up_taken);
        miss_s     = up_pred ^ up_taken;
    end

    // Pattern history table: cleared on reset, one entry stepped per update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pht_r <= '0;
        end else if (up_valid) begin
            pht_r[up_index] <= pht_next_s;
        end
    end

    generate
        if (GHR_BITS == 0) begin : g_ghr_none
            // No history kept: the register stays at zero
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr_r <= '0;
                end else begin
                    ghr_r <= '0;
                end
            end
        end else if (GHR_BITS == 1) begin : g_ghr_one
            // One-bit history simply remembers the last resolved outcome
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr_r <= '0;
                end else if (up_valid) begin
                    ghr_r <= up_taken;
                end
            end
        end else begin : g_ghr_shift
            // Multi-bit history shifts in the newest outcome at the LSB
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr_r <= '0;
                end else if (up_valid) begin
                    ghr_r <= {ghr_r[GW-2:0], up_taken};
                end
            end
        end
    endgenerate

    // Misprediction flag: reflects only the update of the previous cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_r <= 1'b0;
        end else begin
            mispredict_r <= up_valid & miss_s;
        end
    end

    // Statistics: clear beats a same-cycle increment; both counters saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_r <= '0;
            stat_miss_r     <= '0;
        end else if (stat_clr) begin
            stat_branches_r <= '0;
            stat_miss_r     <= '0;
        end else if (up_valid) begin
            stat_branches_r <= stat_inc(stat_branches_r);
            if (miss_s) begin
                stat_miss_r <= stat_inc(stat_miss_r);
            end
        end
    end

    // Drive the registered outputs
    always_comb begin
        mispredict    = mispredict_r;
        stat_branches = stat_branches_r;
        stat_miss     = stat_miss_r;
        ghr           = ghr_r;
    end

endmodule
